// File: rtl/pwm_ramp_pkg.sv
// Shared types and constants for the PWM soft-start controller: FSM states, full-scale duty and
// the speed-code to target-duty table.
package pwm_ramp_pkg;

   localparam int unsigned PWM_DUTY_W = 8;
   localparam logic [PWM_DUTY_W-1:0] PWM_MAX = 8'd255;

   typedef enum logic [1:0] {
      StIdle,
      StRampUp,
      StRampDown,
      StHold
   } ramp_state_e;

   // Roughly linear steps of 36, with the top code pinned to full scale.
   function automatic logic [PWM_DUTY_W-1:0] level(input logic [2:0] code);
      logic [PWM_DUTY_W-1:0] lvl;
      unique case (code)
         3'd0:    lvl = 8'd0;
         3'd1:    lvl = 8'd36;
         3'd2:    lvl = 8'd72;
         3'd3:    lvl = 8'd108;
         3'd4:    lvl = 8'd144;
         3'd5:    lvl = 8'd180;
         3'd6:    lvl = 8'd216;
         default: lvl = PWM_MAX;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM period counter, period-boundary strobe and registered duty compare.
// The counter is parked at 0 whenever run_i is low.
module pwm_core
   import pwm_ramp_pkg::*;
#(
   parameter int unsigned DUTY_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run_i,
   input  logic [DUTY_W-1:0] duty_now_i,
   output logic              pwm_o,
   output logic              pb_o
);

   // Period is 2^DUTY_W-1 cycles so that full-scale duty gives a solid high.
   localparam logic [DUTY_W-1:0] CntLast = DUTY_W'((1 << DUTY_W) - 2);

   logic [DUTY_W-1:0] cnt_q, cnt_d;
   logic              pwm_q, pwm_d;

   always_comb begin
      pb_o  = run_i && (cnt_q == CntLast);
      pwm_d = (cnt_q < duty_now_i);
      if (!run_i || pb_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pwm_q <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Soft-start/soft-stop PWM controller: slews the live duty toward the speed-code target, one
// STEP per ramp tick, updating only at period boundaries. Define PWM_SYNC_IN_EN to synchronize
// enable/speed/ramp_rate through 2-flop chains.
module pwm_ramp_ctrl
   import pwm_ramp_pkg::*;
#(
   parameter int unsigned DUTY_W = 8,
   parameter int unsigned STEP   = 4,
   parameter int unsigned RATE_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [2:0]        speed,
   input  logic [RATE_W-1:0] ramp_rate,
   output logic              pwm,
   output logic [DUTY_W-1:0] duty_now,
   output logic              busy,
   output logic              at_target
);

   // Tick counter must reach 2^(2^RATE_W-1) pb events.
   localparam int unsigned TickW = (1 << RATE_W) - 1;
   localparam logic [TickW:0] TickOne = (TickW + 1)'(1);
   localparam logic [DUTY_W:0] StepX = (DUTY_W + 1)'(STEP);

   logic              en_s;
   logic [2:0]        speed_s;
   logic [RATE_W-1:0] rate_s;

`ifdef PWM_SYNC_IN_EN
   logic [1:0]             en_sync_q, en_sync_d;
   logic [1:0][2:0]        speed_sync_q, speed_sync_d;
   logic [1:0][RATE_W-1:0] rate_sync_q, rate_sync_d;

   always_comb begin
      en_sync_d    = {en_sync_q[0], enable};
      speed_sync_d = {speed_sync_q[0], speed};
      rate_sync_d  = {rate_sync_q[0], ramp_rate};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_sync_q    <= '0;
         speed_sync_q <= '0;
         rate_sync_q  <= '0;
      end else begin
         en_sync_q    <= en_sync_d;
         speed_sync_q <= speed_sync_d;
         rate_sync_q  <= rate_sync_d;
      end
   end

   assign en_s    = en_sync_q[1];
   assign speed_s = speed_sync_q[1];
   assign rate_s  = rate_sync_q[1];
`else
   assign en_s    = enable;
   assign speed_s = speed;
   assign rate_s  = ramp_rate;
`endif

   ramp_state_e       state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [TickW-1:0]  tick_q, tick_d;

   logic              pb;
   logic              tick_fire;
   logic [TickW:0]    tick_lim;
   logic [DUTY_W-1:0] tgt;
   logic [DUTY_W:0]   tgt_x, duty_x, up_sum;
   logic [DUTY_W-1:0] up_sat, dn_sat;
   ramp_state_e       park_st;

   pwm_core #(
      .DUTY_W (DUTY_W)
   ) u_pwm_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .run_i      (state_q != StIdle),
      .duty_now_i (duty_q),
      .pwm_o      (pwm),
      .pb_o       (pb)
   );

   // Saturating slew toward the target, one extra bit so nothing wraps.
   always_comb begin
      tgt      = en_s ? DUTY_W'(level(speed_s)) : '0;
      tgt_x    = {1'b0, tgt};
      duty_x   = {1'b0, duty_q};
      up_sum   = duty_x + StepX;
      up_sat   = (up_sum >= tgt_x) ? tgt : up_sum[DUTY_W-1:0];
      dn_sat   = (duty_x <= tgt_x + StepX) ? tgt : DUTY_W'(duty_x - StepX);
      tick_lim = TickOne << rate_s;
      tick_fire = ({1'b0, tick_q} + TickOne) >= tick_lim;
      park_st  = en_s ? StHold : StIdle;
   end

   // A direction change is taken on its own pb; the step waits for a later tick.
   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      unique case (state_q)
         StIdle: begin
            if (en_s && (tgt != '0)) begin
               state_d = StRampUp;
            end
         end
         StRampUp: begin
            if (pb) begin
               if (!en_s || (tgt < duty_q)) begin
                  state_d = StRampDown;
               end else if (tgt == duty_q) begin
                  state_d = StHold;
               end else if (tick_fire) begin
                  duty_d = up_sat;
                  if (up_sat == tgt) begin
                     state_d = StHold;
                  end
               end
            end
         end
         StRampDown: begin
            if (pb) begin
               if (tgt > duty_q) begin
                  state_d = StRampUp;
               end else if (tgt == duty_q) begin
                  state_d = park_st;
               end else if (tick_fire) begin
                  duty_d = dn_sat;
                  if (dn_sat == tgt) begin
                     state_d = park_st;
                  end
               end
            end
         end
         StHold: begin
            if (pb) begin
               if (tgt > duty_q) begin
                  state_d = StRampUp;
               end else if ((tgt < duty_q) || !en_s) begin
                  state_d = StRampDown;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      tick_d = tick_q;
      if (state_d != state_q) begin
         tick_d = '0;
      end else if (pb) begin
         tick_d = tick_fire ? '0 : tick_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         duty_q  <= '0;
         tick_q  <= '0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         tick_q  <= tick_d;
      end
   end

   assign duty_now  = duty_q;
   assign busy      = (state_q == StRampUp) || (state_q == StRampDown);
   assign at_target = (state_q == StHold);

endmodule
